// File: rtl/up3_loader_pkg.sv
// Shared types for the UP3 program loader: state encoding, error codes, length helper.
// UP3_LOADER_VERIFY_EN adds the read-back VERIFY state.
package up3_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
`ifdef UP3_LOADER_VERIFY_EN
      ST_VERIFY = 3'd2,
`endif
      ST_DONE   = 3'd3,
      ST_ERROR  = 3'd4
   } loader_state_t;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT = 2'b01;
   localparam logic [1:0] ERR_VERIFY  = 2'b10;

   // A zero length stands for the full 2**addr_w address space.
   function automatic logic [15:0] eff_len(input logic [15:0] len, input int addr_w);
      return (len == 16'd0) ? 16'(1 << addr_w) : len;
   endfunction

endpackage

// File: rtl/up3_prog_loader_if.sv
// Byte-stream input, RAM write port and status bundle of the UP3 program loader.
// master = loader side, slave = byte source / RAM / CPU side.
interface up3_prog_loader_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              start;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] len;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_data;
   logic              ram_wren;
   logic [DATA_W-1:0] ram_q;
   logic              cpu_hold;
   logic              done;
   logic              error;
   logic [1:0]        err_code;
   logic [DATA_W-1:0] checksum;

   modport master (
      input  start, base, len, in_valid, in_data, ram_q,
      output in_ready, ram_addr, ram_data, ram_wren, cpu_hold, done, error, err_code, checksum
   );

   modport slave (
      output start, base, len, in_valid, in_data, ram_q,
      input  in_ready, ram_addr, ram_data, ram_wren, cpu_hold, done, error, err_code, checksum
   );
endinterface

// File: rtl/up3_load_timer.sv
// Idle-cycle counter: clears on clr, counts while en, saturates; expire on the TIMEOUT_CYCLES-th idle cycle.
// Latency: expire is combinational from the registered count. TIMEOUT_CYCLES=0 never expires.
module up3_load_timer #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);
   generate
      if (TIMEOUT_CYCLES == 0) begin : g_off
         logic unused_in;
         assign unused_in = clr ^ en;
         assign expire    = 1'b0;
      end else begin : g_on
         localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
         localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
         logic [CW-1:0] cnt;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                   cnt <= '0;
            else if (clr)                 cnt <= '0;
            else if (en && cnt != LAST)   cnt <= cnt + CW'(1);
         end

         assign expire = en && (cnt == LAST);
      end
   endgenerate
endmodule

// File: rtl/up3_prog_loader.sv
// UP3 RAM loader: writes a byte stream from base upward, holds the CPU until done (UP3_LOADER_VERIFY_EN adds read-back).
// Latency: each accepted byte is written 1 cycle later; done rises 1 cycle after the last write (+len+1 with VERIFY).
// Backpressure: in_ready depends only on registered state; it drops once len bytes are accepted.
module up3_prog_loader
   import up3_loader_pkg::*;
#(
   parameter int ADDR_W         = 8,
   parameter int DATA_W         = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              reset,
   up3_prog_loader_if.master bus
);
   localparam int CNT_W = ADDR_W + 1;

   loader_state_t     state;
   logic [ADDR_W-1:0] base_r, ram_addr_r;
   logic [CNT_W-1:0]  len_r, idx;
   logic [DATA_W-1:0] ram_data_r, sum_r;
   logic              ram_wren_r, cpu_hold_r, done_r, error_r;
   logic [1:0]        err_code_r;
   logic              in_ready_c, accept, start_ok, expire;

   assign in_ready_c = (state == ST_LOAD) && (idx != len_r);
   assign accept     = bus.in_valid && in_ready_c;
   assign start_ok   = bus.start && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);

   up3_load_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk    (clk),
      .rst_n  (reset),
      .clr    (accept || start_ok),
      .en     (state == ST_LOAD),
      .expire (expire)
   );

`ifdef UP3_LOADER_VERIFY_EN
   logic [DATA_W-1:0] vsum, vsum_next;
   assign vsum_next = vsum + bus.ram_q;
`else
   logic unused_ram_q;
   assign unused_ram_q = ^bus.ram_q;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         base_r     <= '0;
         len_r      <= '0;
         idx        <= '0;
         sum_r      <= '0;
         ram_addr_r <= '0;
         ram_data_r <= '0;
         ram_wren_r <= 1'b0;
         cpu_hold_r <= 1'b1;
         done_r     <= 1'b0;
         error_r    <= 1'b0;
         err_code_r <= ERR_NONE;
`ifdef UP3_LOADER_VERIFY_EN
         vsum       <= '0;
`endif
      end else begin
         ram_wren_r <= 1'b0;
         if (start_ok) begin
            state      <= ST_LOAD;
            base_r     <= bus.base;
            len_r      <= CNT_W'(eff_len(16'(bus.len), ADDR_W));
            idx        <= '0;
            sum_r      <= '0;
            cpu_hold_r <= 1'b1;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            err_code_r <= ERR_NONE;
         end else begin
            case (state)
               ST_LOAD: begin
                  if (accept) begin
                     ram_wren_r <= 1'b1;
                     ram_addr_r <= base_r + idx[ADDR_W-1:0];
                     ram_data_r <= bus.in_data;
                     sum_r      <= sum_r + bus.in_data;
                     idx        <= idx + CNT_W'(1);
                  end else if (idx == len_r) begin
                     // Reached in the cycle the final write is on the RAM port.
`ifdef UP3_LOADER_VERIFY_EN
                     state      <= ST_VERIFY;
                     ram_addr_r <= base_r;
                     idx        <= '0;
                     vsum       <= '0;
`else
                     state      <= ST_DONE;
                     done_r     <= 1'b1;
                     cpu_hold_r <= 1'b0;
`endif
                  end else if (expire) begin
                     state      <= ST_ERROR;
                     error_r    <= 1'b1;
                     err_code_r <= ERR_TIMEOUT;
                  end
               end
`ifdef UP3_LOADER_VERIFY_EN
               ST_VERIFY: begin
                  // ram_q in cycle idx is the byte at the address presented in cycle idx-1.
                  if (idx == len_r) begin
                     if (vsum_next == sum_r) begin
                        state      <= ST_DONE;
                        done_r     <= 1'b1;
                        cpu_hold_r <= 1'b0;
                     end else begin
                        state      <= ST_ERROR;
                        error_r    <= 1'b1;
                        err_code_r <= ERR_VERIFY;
                     end
                  end else begin
                     if (idx != '0) vsum <= vsum_next;
                     ram_addr_r <= base_r + idx[ADDR_W-1:0] + ADDR_W'(1);
                     idx        <= idx + CNT_W'(1);
                  end
               end
`endif
               default: ;
            endcase
         end
      end
   end

   assign bus.in_ready = in_ready_c;
   assign bus.ram_addr = ram_addr_r;
   assign bus.ram_data = ram_data_r;
   assign bus.ram_wren = ram_wren_r;
   assign bus.cpu_hold = cpu_hold_r;
   assign bus.done     = done_r;
   assign bus.error    = error_r;
   assign bus.err_code = err_code_r;
   assign bus.checksum = sum_r;
endmodule

// File: tb/tb_up3_prog_loader.sv
// Bench for up3_prog_loader: random byte streams against a list-of-writes / checksum reference model.
module tb_up3_prog_loader;
   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   int   last_acc_cyc = 0;
   bit   corrupt11 = 1'b0;
   logic [7:0] mem [256];
   logic [7:0] src [$];
   int   wr_addr [$], wr_data [$], wr_cyc [$];
   int   exp_addr [$], exp_data [$];

`ifdef UP3_LOADER_VERIFY_EN
   localparam bit VERIFY_ON = 1'b1;
`else
   localparam bit VERIFY_ON = 1'b0;
`endif
   localparam logic [30:0] RST_VEC = 31'h0000_1000;

   always #5 clk = ~clk;

   up3_prog_loader_if #(.ADDR_W(8), .DATA_W(8)) bus ();

   up3_prog_loader #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYCLES(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // RAM model: synchronous write, registered read, optional corruption of 0x11.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.ram_wren === 1'b1)
         mem[bus.ram_addr] <= (corrupt11 && bus.ram_addr == 8'h11) ? ~bus.ram_data : bus.ram_data;
      bus.ram_q <= mem[bus.ram_addr];
   end

   always @(negedge clk) begin
      if (reset) begin
         if (bus.ram_wren === 1'b1) begin
            wr_addr.push_back(int'(bus.ram_addr));
            wr_data.push_back(int'(bus.ram_data));
            wr_cyc.push_back(cyc);
         end
         if (bus.done === 1'b1 && bus.error === 1'b1) begin
            n_bad++;
            $display("FAIL done_error_both: done=1 error=1 at cycle %0d, required never both", cyc);
         end
         if ((bus.done | bus.error) === 1'b1 && bus.ram_wren !== 1'b0) begin
            n_bad++;
            $display("FAIL wren_after_load: ram_wren=%b at cycle %0d, required 0", bus.ram_wren, cyc);
         end
      end
   end

   function automatic logic [30:0] out_vec();
      return {bus.in_ready, bus.ram_wren, bus.ram_addr, bus.ram_data, bus.cpu_hold,
              bus.done, bus.error, bus.err_code, bus.checksum};
   endfunction

   function automatic void fill_src(input int n);
      src.delete();
      for (int i = 0; i < n; i++) src.push_back(8'($urandom_range(255)));
   endfunction

   function automatic void build_expected(input int b, input int n);
      exp_addr.delete();
      exp_data.delete();
      for (int i = 0; i < n; i++) begin
         exp_addr.push_back((b + i) % 256);
         exp_data.push_back(int'(src[i]));
      end
   endfunction

   function automatic int model_sum(input int n);
      int s = 0;
      for (int i = 0; i < n; i++) s += int'(src[i]);
      return s % 256;
   endfunction

   function automatic int eff(input int l);
      return (l == 0) ? 256 : l;
   endfunction

   function automatic int bad_writes();
      int nb = 0;
      for (int i = 0; i < exp_addr.size(); i++)
         if (i >= wr_addr.size() || wr_addr[i] != exp_addr[i] || wr_data[i] != exp_data[i]) nb++;
      return nb;
   endfunction

   task automatic do_start(input logic [7:0] b, input logic [7:0] l);
      @(posedge clk); #1;
      wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
      bus.start = 1'b1; bus.base = b; bus.len = l;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   // Presents src[0..n-1]; gap_pct inserts idle cycles (at most 3 in a row); noise_at pulses a stray start.
   task automatic stream(input int n, input int gap_pct, input int noise_at);
      int i = 0, guard = 0, run = 0;
      bit acc;
      while (i < n && guard < 4000) begin
         guard++;
         if (run < 3 && $urandom_range(99) < gap_pct) begin
            bus.in_valid = 1'b0; run++;
         end else begin
            bus.in_valid = 1'b1; bus.in_data = src[i]; run = 0;
         end
         if (i == noise_at) begin bus.start = 1'b1; bus.base = 8'h55; bus.len = 8'h07; end
         @(negedge clk);
         acc = bus.in_valid && bus.in_ready;
         if (acc) last_acc_cyc = cyc;
         @(posedge clk); #1;
         bus.start = 1'b0;
         if (acc) i++;
      end
      bus.in_valid = 1'b0;
      if (i < n) begin
         n_vec++; n_bad++;
         $display("FAIL stream_stall: accepted %0d bytes, required %0d", i, n);
      end
   endtask

   task automatic wait_end(output int c);
      c = -1;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (bus.done === 1'b1 || bus.error === 1'b1) begin c = cyc; break; end
      end
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.base = '0; bus.len = '0; bus.in_valid = 1'b0; bus.in_data = '0;
      reset = 1'b0;
      #12;
      n_vec++;
      if (out_vec() !== RST_VEC) begin
         n_bad++; $display("FAIL reset_outputs: got %h, required %h", out_vec(), RST_VEC);
      end
      @(negedge clk); #2 reset = 1'b1;
   endtask

   task automatic test_basic();
      int c;
      src = '{8'h01, 8'h02, 8'h03, 8'h04};
      build_expected(8'h10, 4);
      do_start(8'h10, 8'h04);
      stream(4, 0, -1);
      wait_end(c);
      n_vec++;
      if (wr_addr.size() !== 4 || bad_writes() !== 0) begin
         n_bad++; $display("FAIL basic_writes: %0d writes, %0d wrong, required 4 writes to 0x10..0x13", wr_addr.size(), bad_writes());
      end
      n_vec++;
      if (wr_cyc.size() == 4 && wr_cyc[3] - wr_cyc[0] !== 3) begin
         n_bad++; $display("FAIL basic_back_to_back: writes span %0d cycles, required 3", wr_cyc[3] - wr_cyc[0]);
      end
      n_vec++;
      if (bus.checksum !== 8'h0A) begin
         n_bad++; $display("FAIL basic_checksum: got %h, required 0a", bus.checksum);
      end
      n_vec++;
      if (wr_cyc.size() == 0 || c !== wr_cyc[wr_cyc.size()-1] + 1 + (VERIFY_ON ? 5 : 0)) begin
         n_bad++; $display("FAIL basic_done_time: done at cycle %0d, last write at %0d", c, (wr_cyc.size() == 0) ? -1 : wr_cyc[wr_cyc.size()-1]);
      end
      n_vec++;
      if ({bus.done, bus.error, bus.cpu_hold, bus.in_ready} !== 4'b1000) begin
         n_bad++; $display("FAIL basic_status: done/error/cpu_hold/in_ready=%b, required 1000", {bus.done, bus.error, bus.cpu_hold, bus.in_ready});
      end
   endtask

   task automatic test_wrap();
      int c;
      fill_src(3);
      build_expected(8'hFE, 3);
      do_start(8'hFE, 8'h03);
      stream(3, 0, -1);
      bus.in_valid = 1'b1;
      @(negedge clk);
      n_vec++;
      if (bus.in_ready !== 1'b0) begin
         n_bad++; $display("FAIL wrap_in_ready: got %b after final accept, required 0", bus.in_ready);
      end
      @(posedge clk); #1 bus.in_valid = 1'b0;
      wait_end(c);
      n_vec++;
      if (wr_addr.size() !== 3 || bad_writes() !== 0) begin
         n_bad++; $display("FAIL wrap_writes: %0d writes, %0d wrong, required fe,ff,00", wr_addr.size(), bad_writes());
      end
      n_vec++;
      if (int'(bus.checksum) !== model_sum(3) || bus.done !== 1'b1) begin
         n_bad++; $display("FAIL wrap_end: checksum %h done %b, required %h and 1", bus.checksum, bus.done, model_sum(3));
      end
   endtask

   task automatic test_timeout();
      int c;
      logic [7:0] b;
      b = 8'($urandom_range(255));
      fill_src(4);
      do_start(b, 8'h04);
      stream(2, 0, -1);
      wait_end(c);
      n_vec++;
      if (c !== last_acc_cyc + 1 + 8) begin
         n_bad++; $display("FAIL timeout_delay: error %0d cycles after last accept, required 8", c - last_acc_cyc - 1);
      end
      n_vec++;
      if ({bus.error, bus.err_code, bus.cpu_hold, bus.done, bus.in_ready} !== 6'b101100) begin
         n_bad++; $display("FAIL timeout_status: error/err_code/cpu_hold/done/in_ready=%b, required 101100",
                           {bus.error, bus.err_code, bus.cpu_hold, bus.done, bus.in_ready});
      end
      n_vec++;
      if (wr_addr.size() !== 2) begin
         n_bad++; $display("FAIL timeout_writes: %0d writes, required 2", wr_addr.size());
      end
      b = 8'($urandom_range(255));
      fill_src(5);
      build_expected(b, 5);
      do_start(b, 8'h05);
      stream(5, 20, -1);
      wait_end(c);
      n_vec++;
      if (bus.done !== 1'b1 || bus.err_code !== 2'b00 || bad_writes() !== 0 || int'(bus.checksum) !== model_sum(5)) begin
         n_bad++; $display("FAIL timeout_recover: done %b err_code %b bad writes %0d checksum %h, required 1 00 0 %h",
                           bus.done, bus.err_code, bad_writes(), bus.checksum, model_sum(5));
      end
   endtask

   task automatic test_reset_mid();
      int c;
      logic [7:0] b;
      b = 8'($urandom_range(255));
      fill_src(5);
      do_start(b, 8'h05);
      stream(2, 0, -1);
      #2 reset = 1'b0;
      #1;
      n_vec++;
      if (out_vec() !== RST_VEC) begin
         n_bad++; $display("FAIL reset_mid_outputs: got %h, required %h", out_vec(), RST_VEC);
      end
      #3 reset = 1'b1;
      fill_src(5);
      build_expected(b, 5);
      do_start(b, 8'h05);
      stream(5, 0, -1);
      wait_end(c);
      n_vec++;
      if (bus.done !== 1'b1 || wr_addr.size() !== 5 || bad_writes() !== 0 || int'(bus.checksum) !== model_sum(5)) begin
         n_bad++; $display("FAIL reset_mid_reload: done %b writes %0d bad %0d checksum %h, required 1 5 0 %h",
                           bus.done, wr_addr.size(), bad_writes(), bus.checksum, model_sum(5));
      end
   endtask

   task automatic test_verify();
`ifdef UP3_LOADER_VERIFY_EN
      int c;
      fill_src(4);
      corrupt11 = 1'b1;
      do_start(8'h10, 8'h04);
      stream(4, 0, -1);
      wait_end(c);
      corrupt11 = 1'b0;
      n_vec++;
      if ({bus.error, bus.err_code, bus.done, bus.cpu_hold} !== 5'b11001) begin
         n_bad++; $display("FAIL verify_corrupt: error/err_code/done/cpu_hold=%b, required 11001",
                           {bus.error, bus.err_code, bus.done, bus.cpu_hold});
      end
      do_start(8'h10, 8'h04);
      stream(4, 0, -1);
      wait_end(c);
      n_vec++;
      if ({bus.error, bus.err_code, bus.done, bus.cpu_hold} !== 5'b00010) begin
         n_bad++; $display("FAIL verify_clean: error/err_code/done/cpu_hold=%b, required 00010",
                           {bus.error, bus.err_code, bus.done, bus.cpu_hold});
      end
`endif
   endtask

   task automatic test_full();
      int c;
      fill_src(256);
      build_expected(0, 256);
      do_start(8'h00, 8'h00);
      stream(256, 10, 100);
      wait_end(c);
      n_vec++;
      if (wr_addr.size() !== 256 || bad_writes() !== 0) begin
         n_bad++; $display("FAIL full_writes: %0d writes, %0d wrong, required 256 to 00..ff", wr_addr.size(), bad_writes());
      end
      n_vec++;
      if (wr_addr.size() == 0 || wr_addr[wr_addr.size()-1] !== 255) begin
         n_bad++; $display("FAIL full_last_addr: got %0d, required 255", (wr_addr.size() == 0) ? -1 : wr_addr[wr_addr.size()-1]);
      end
      n_vec++;
      if (int'(bus.checksum) !== model_sum(256) || bus.done !== 1'b1) begin
         n_bad++; $display("FAIL full_end: checksum %h done %b, required %h and 1", bus.checksum, bus.done, model_sum(256));
      end
   endtask

   task automatic test_random();
      int c, b, l, n;
      for (int t = 0; t < 6; t++) begin
         b = (t == 0) ? 8'h80 : $urandom_range(255);
         l = (t == 0) ? 0 : $urandom_range(1, 40);
         n = eff(l);
         fill_src(n);
         build_expected(b, n);
         do_start(8'(b), 8'(l));
         stream(n, 30, -1);
         wait_end(c);
         n_vec++;
         if (wr_addr.size() !== n || bad_writes() !== 0) begin
            n_bad++; $display("FAIL random_writes[%0d]: base %h len %0d: %0d writes, %0d wrong", t, b, l, wr_addr.size(), bad_writes());
         end
         n_vec++;
         if (int'(bus.checksum) !== model_sum(n) || bus.done !== 1'b1 || bus.cpu_hold !== 1'b0) begin
            n_bad++; $display("FAIL random_end[%0d]: checksum %h done %b cpu_hold %b, required %h 1 0",
                              t, bus.checksum, bus.done, bus.cpu_hold, model_sum(n));
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_timeout();
      test_reset_mid();
      test_verify();
      test_full();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/up3_prog_loader.md
Name: up3_prog_loader

Overview:
Writer-side front end for the UP3 program/data RAM. Accepts a byte stream over a valid/ready handshake and writes it to consecutive RAM addresses from a base address. Holds the UP3 CPU in reset until the load completes, then releases it. Sits between an external byte source (switch/UART front end) and the RAM write port, muxed ahead of the CPU's address, data and write-enable path.

Parameters:
ADDR_W, 8, RAM address width; the RAM is 256 x 8.
DATA_W, 8, RAM data and stream byte width.
TIMEOUT_CYCLES, 1024, maximum idle cycles between accepted bytes in LOAD; 0 disables the timeout.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle pulse; latches base and len
base  input  ADDR_W  first RAM address to write
len  input  ADDR_W  byte count; 0 means 256
in_valid  input  1  stream byte valid
in_data  input  DATA_W  stream byte
in_ready  output  1  loader accepts a byte this cycle
ram_addr  output  ADDR_W  RAM address
ram_data  output  DATA_W  RAM write data
ram_wren  output  1  RAM write enable
ram_q  input  DATA_W  RAM read data; valid 1 cycle after ram_addr is presented
cpu_hold  output  1  1 = hold the UP3 CPU in reset and give the loader the RAM port
done  output  1  level; load finished successfully
error  output  1  level; load aborted
err_code  output  2  00 none, 01 timeout, 10 verify mismatch
checksum  output  DATA_W  mod-256 sum of the bytes accepted in the current load

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, cpu_hold=1, done=0, error=0, err_code=00, checksum=0, ram_wren=0, ram_addr=0, ram_data=0, in_ready=0. A reset mid-load abandons the load; bytes already written stay in RAM.
- States: IDLE, LOAD, VERIFY (only when the macro is defined), DONE, ERROR.
- IDLE: on start, latch base and len; clear the index, checksum and timer; go to LOAD.
- DONE and ERROR: a start pulse re-enters LOAD and restarts the whole sequence. cpu_hold returns to 1 on the cycle after that start.
- LOAD:
  - in_ready = (state==LOAD) && (accepted count != effective len). in_ready is combinational from registered state only; it never depends on in_valid.
  - A byte is accepted when in_valid && in_ready. On the next cycle: ram_wren=1, ram_addr=(base+index) mod 256, ram_data=byte. Write latency is 1 cycle.
  - Each accept updates checksum += byte (mod 256) and index++.
  - Back-to-back accepts are allowed, giving one write per cycle.
  - After the final write cycle, the next state is VERIFY when enabled, otherwise DONE.
- Timeout (LOAD only, TIMEOUT_CYCLES>0):
  - The timer clears on every accept.
  - If TIMEOUT_CYCLES consecutive cycles pass with no accept, go to ERROR with err_code=01.
  - An accept in the same cycle the timer expires wins; no error is raised.
- start in LOAD or VERIFY is ignored.
- Address wrap: base+index wraps modulo 256. len=0 with base=0x80 writes 0x80..0xFF, then 0x00..0x7F.
- DONE: cpu_hold=0, done=1, in_ready=0, ram_wren=0.
- ERROR: cpu_hold=1, error=1, in_ready=0.
- done and error are never both 1.
- ram_wren is 0 in every state except the LOAD write cycles.

Optional Feature:
UP3_LOADER_VERIFY_EN
- Defined:
  - VERIFY reads back every loaded address in order, one address per cycle, with ram_wren=0.
  - It sums ram_q, sampled 1 cycle after each address.
  - After the last sample: sum == checksum goes to DONE; a mismatch goes to ERROR with err_code=10.
  - VERIFY takes effective len + 1 cycles.
- Not defined: no VERIFY state; LOAD goes straight to DONE, and err_code=10 is never produced.

Decomposition:
- Package up3_loader_pkg holds:
  - the state enum loader_state_t;
  - err_code localparams ERR_NONE, ERR_TIMEOUT, ERR_VERIFY;
  - the effective-length helper function (0 maps to 256).
- Sub-module up3_load_timer: a clearable, saturating idle-cycle counter with an expire output, parameterised by TIMEOUT_CYCLES.

Test Plan:
- base=0x10, len=4, bytes 0x01,0x02,0x03,0x04 back-to-back -> writes to 0x10..0x13 on consecutive cycles; checksum=0x0A; done=1 and cpu_hold=0 one cycle after the last write (one cycle after VERIFY ends if enabled).
- base=0xFE, len=3 -> writes to 0xFE, 0xFF, 0x00; in_ready=0 after the third accept even with in_valid held high.
- TIMEOUT_CYCLES=8, len=4, stream stalls after 2 bytes -> error=1, err_code=01, cpu_hold=1 exactly 8 cycles after the last accept; a new start recovers.
- reset pulsed low mid-LOAD after 2 of 5 bytes -> all outputs at reset values immediately; the next start loads cleanly.
- VERIFY enabled, RAM model corrupts 0x11 after it is written -> err_code=10, done=0; an unmodified RAM gives done=1.
- len=0, base=0 -> 256 writes, final write to address 0xFF; start pulses during LOAD are ignored.
